// File: rtl/fp_pkg.sv
// Shared floating-point helpers: format constants, canonical NaN builder and
// the sequencer state encoding used by the iterative FP units.
package fp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPECIAL,
        DIVIDE,
        NORM_ROUND,
        DONE
    } fp_state_t;

    // Widest operand the NaN builder can describe; callers slice what they need.
    localparam int FP_MAX_W = 128;

    function automatic int fp_bias(input int exponent_width);
        return (1 << (exponent_width - 1)) - 1;
    endfunction

    function automatic int fp_exp_ones(input int exponent_width);
        return (1 << exponent_width) - 1;
    endfunction

    function automatic int fp_quiet_bit(input int mantissa_width);
        return mantissa_width - 1;
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exponent_width,
                                                    input int mantissa_width,
                                                    input logic sign);
        logic [FP_MAX_W-1:0] v;
        v = '0;
        v[exponent_width + mantissa_width] = sign;
        for (int i = 0; i < exponent_width; i++) begin
            v[mantissa_width + i] = 1'b1;
        end
        v[fp_quiet_bit(mantissa_width)] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier: zero, denormal, infinity, NaN and signalling NaN.
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23
) (
    input  logic [EXPONENT_WIDTH-1:0] exponent,
    input  logic [MANTISSA_WIDTH-1:0] fraction,
    output logic                      is_zero,
    output logic                      is_denorm,
    output logic                      is_inf,
    output logic                      is_nan,
    output logic                      is_snan
);

    localparam int QUIET_BIT = fp_quiet_bit(MANTISSA_WIDTH);

    logic exp_zero;
    logic exp_ones;
    logic frac_zero;

    assign exp_zero  = (exponent == '0);
    assign exp_ones  = &exponent;
    assign frac_zero = (fraction == '0);

    assign is_zero   = exp_zero & frac_zero;
    assign is_denorm = exp_zero & ~frac_zero;
    assign is_inf    = exp_ones & frac_zero;
    assign is_nan    = exp_ones & ~frac_zero;
    assign is_snan   = is_nan & ~fraction[QUIET_BIT];

endmodule

// File: rtl/floating_point_divider.sv
// Iterative floating-point divider: one restoring-division quotient bit per cycle,
// round-to-nearest-even, denormals flushed to zero, start/busy/done handshake.
module floating_point_divider
    import fp_pkg::*;
#(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]   a,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]   b,
    output logic                                     busy,
    output logic                                     done,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]   out,
    output logic                                     underflow_flag,
    output logic                                     overflow_flag,
    output logic                                     invalid_operation_flag,
    output logic                                     divide_by_zero_flag
);

    localparam int EW    = EXPONENT_WIDTH;
    localparam int MW    = MANTISSA_WIDTH;
    localparam int W     = EW + MW + 1;
    localparam int CNT_W = $clog2(MW + 2);

    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(MW + 1);
    localparam logic signed [EW+1:0] BIAS_S    = (EW+2)'(fp_bias(EW));
    localparam logic signed [EW+1:0] EXP_MAX_S = (EW+2)'(fp_exp_ones(EW));
    localparam logic [EW-1:0]        EXP_ONES  = '1;
    localparam logic [FP_MAX_W-1:0]  QNAN_WIDE = fp_qnan(EW, MW, 1'b0);
    localparam logic [W-2:0]         QNAN_MAG  = QNAN_WIDE[W-2:0];

    function automatic logic [MW+1:0] round_rne(input logic [MW:0] mant,
                                                input logic guard,
                                                input logic rnd,
                                                input logic sticky);
        logic up;
        up = guard & (rnd | sticky | mant[0]);
        return {1'b0, mant} + (MW+2)'(up);
    endfunction

    fp_state_t state, state_next;

    logic a_zero_in, a_den_in, a_inf_in, a_nan_in, a_snan_in;
    logic b_zero_in, b_den_in, b_inf_in, b_nan_in, b_snan_in;
    logic special_in, accept;

    logic          a_sign, b_sign;
    logic [EW-1:0] a_exp, b_exp;
    logic [MW-1:0] a_frac, b_frac;
    logic          a_zero_r, a_den_r, a_inf_r, a_nan_r, a_snan_r;
    logic          b_zero_r, b_den_r, b_inf_r, b_nan_r, b_snan_r;
    logic          q_sign;

    logic [MW+1:0]  rem;
    logic [MW+2:0]  quo;
    logic [CNT_W-1:0] cnt;

    logic [MW:0]   man_a_in, man_b_in;
    logic          first_bit;
    logic [MW+1:0] rem_first;
    logic          rem_ge;
    logic [MW+1:0] rem_diff;

    logic [W-1:0] spec_out;
    logic         spec_of, spec_inv, spec_dbz;

    logic signed [EW+1:0] exp_q, exp_n, exp_f;
    logic [MW:0]          mant_n;
    logic                 guard_n, rnd_n, sticky_n;
    logic [MW+1:0]        rounded;
    logic [MW-1:0]        frac_n;
    logic [W-1:0]         norm_out;
    logic                 norm_of, norm_uf;

    fp_classify #(.EXPONENT_WIDTH(EW), .MANTISSA_WIDTH(MW)) u_class_a (
        .exponent  (a[W-2:MW]),
        .fraction  (a[MW-1:0]),
        .is_zero   (a_zero_in),
        .is_denorm (a_den_in),
        .is_inf    (a_inf_in),
        .is_nan    (a_nan_in),
        .is_snan   (a_snan_in)
    );

    fp_classify #(.EXPONENT_WIDTH(EW), .MANTISSA_WIDTH(MW)) u_class_b (
        .exponent  (b[W-2:MW]),
        .fraction  (b[MW-1:0]),
        .is_zero   (b_zero_in),
        .is_denorm (b_den_in),
        .is_inf    (b_inf_in),
        .is_nan    (b_nan_in),
        .is_snan   (b_snan_in)
    );

    assign special_in = a_zero_in | a_den_in | a_inf_in | a_nan_in |
                        b_zero_in | b_den_in | b_inf_in | b_nan_in;
    assign accept     = start && ((state == IDLE) || (state == DONE));
    assign q_sign     = a_sign ^ b_sign;

    // The integer quotient bit is resolved at capture so DIVIDE only needs MW+2 steps.
    assign man_a_in  = {1'b1, a[MW-1:0]};
    assign man_b_in  = {1'b1, b[MW-1:0]};
    assign first_bit = (man_a_in >= man_b_in);
    assign rem_first = {1'b0, man_a_in} - (first_bit ? {1'b0, man_b_in} : '0);

    assign rem_ge   = (rem >= {1'b0, 1'b1, b_frac});
    assign rem_diff = rem_ge ? (rem - {1'b0, 1'b1, b_frac}) : rem;

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = special_in ? SPECIAL : DIVIDE;
            end
            SPECIAL: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DIVIDE: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) state_next = NORM_ROUND;
            end
            NORM_ROUND: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? (special_in ? SPECIAL : DIVIDE) : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        spec_out = {q_sign, {(W-1){1'b0}}};
        spec_of  = 1'b0;
        spec_inv = 1'b0;
        spec_dbz = 1'b0;
        if (a_nan_r) begin
            spec_inv = 1'b1;
            spec_out = a_snan_r ? {a_sign, QNAN_MAG} : {a_sign, a_exp, a_frac};
        end else if (b_nan_r) begin
            spec_inv = 1'b1;
            spec_out = b_snan_r ? {b_sign, QNAN_MAG} : {b_sign, b_exp, b_frac};
        end else if ((a_zero_r && b_zero_r) || (a_inf_r && b_inf_r)) begin
            spec_inv = 1'b1;
            spec_out = {1'b1, QNAN_MAG};
        end else if (a_inf_r) begin
            spec_of  = 1'b1;
            spec_out = {q_sign, EXP_ONES, {MW{1'b0}}};
        end else if (b_zero_r) begin
            spec_dbz = 1'b1;
            spec_out = {q_sign, EXP_ONES, {MW{1'b0}}};
        end
    end

    always_comb begin
        exp_q    = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + BIAS_S;
        sticky_n = |rem;
        if (quo[MW+2]) begin
            mant_n  = quo[MW+2:2];
            guard_n = quo[1];
            rnd_n   = quo[0];
            exp_n   = exp_q;
        end else begin
            mant_n  = quo[MW+1:1];
            guard_n = quo[0];
            rnd_n   = 1'b0;
            exp_n   = exp_q - 1;
        end
        rounded = round_rne(mant_n, guard_n, rnd_n, sticky_n);
        if (rounded[MW+1]) begin
            frac_n = rounded[MW:1];
            exp_f  = exp_n + 1;
        end else begin
            frac_n = rounded[MW-1:0];
            exp_f  = exp_n;
        end
        norm_of  = 1'b0;
        norm_uf  = 1'b0;
        norm_out = {q_sign, exp_f[EW-1:0], frac_n};
        if (exp_f >= EXP_MAX_S) begin
            norm_of  = 1'b1;
            norm_out = {q_sign, EXP_ONES, {MW{1'b0}}};
        end else if (exp_f <= 0) begin
            norm_uf  = 1'b1;
            norm_out = {q_sign, {(W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= IDLE;
            out                    <= '0;
            underflow_flag         <= 1'b0;
            overflow_flag          <= 1'b0;
            invalid_operation_flag <= 1'b0;
            divide_by_zero_flag    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                underflow_flag         <= 1'b0;
                overflow_flag          <= 1'b0;
                invalid_operation_flag <= 1'b0;
                divide_by_zero_flag    <= 1'b0;
            end
            if (state == SPECIAL) begin
                out                    <= spec_out;
                underflow_flag         <= a_den_r | b_den_r;
                overflow_flag          <= spec_of;
                invalid_operation_flag <= spec_inv;
                divide_by_zero_flag    <= spec_dbz;
            end
            if (state == NORM_ROUND) begin
                out                    <= norm_out;
                underflow_flag         <= norm_uf;
                overflow_flag          <= norm_of;
                invalid_operation_flag <= 1'b0;
                divide_by_zero_flag    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_sign   <= a[W-1];
            a_exp    <= a[W-2:MW];
            a_frac   <= a[MW-1:0];
            b_sign   <= b[W-1];
            b_exp    <= b[W-2:MW];
            b_frac   <= b[MW-1:0];
            a_zero_r <= a_zero_in | a_den_in;
            a_den_r  <= a_den_in;
            a_inf_r  <= a_inf_in;
            a_nan_r  <= a_nan_in;
            a_snan_r <= a_snan_in;
            b_zero_r <= b_zero_in | b_den_in;
            b_den_r  <= b_den_in;
            b_inf_r  <= b_inf_in;
            b_nan_r  <= b_nan_in;
            b_snan_r <= b_snan_in;
            rem      <= rem_first << 1;
            quo      <= {{(MW+2){1'b0}}, first_bit};
            cnt      <= '0;
        end else if (state == DIVIDE) begin
            rem <= rem_diff << 1;
            quo <= {quo[MW+1:0], rem_ge};
            cnt <= cnt + 1'b1;
        end
    end

endmodule
